// File: rtl/pp_tile_buffer.sv
// N-bank ping-pong tile buffer: the producer fills the bank at wr_ptr while the consumer drains
// the bank at rd_ptr; ownership moves around the ring on commit/release.
module pp_tile_buffer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned CW = $clog2(NUM_BANKS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    wr_commit,
    output logic                    wr_ready,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    rd_release,
    output logic                    rd_valid,
    output logic [ADDR_WIDTH:0]     rd_tile_len,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_data_valid,
    output logic [BW-1:0]           wr_bank,
    output logic [BW-1:0]           rd_bank,
    output logic [CW-1:0]           full_cnt,
    input  logic                    err_clr,
    output logic [2:0]              err
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [BW-1:0]         LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [CW-1:0]         NB_CNT    = CW'(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0]   BEAT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][DEPTH];

    logic [BW-1:0]         r_wr_ptr;
    logic [BW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_full_cnt;
    logic [ADDR_WIDTH:0]   r_beats;
    logic [ADDR_WIDTH:0]   r_tile_len [NUM_BANKS];
    logic [2:0]            r_err;
    logic [RD_LATENCY-1:0] r_pvld;
    logic [DATA_WIDTH-1:0] r_pdata [RD_LATENCY];

    logic                  w_wr_ready;
    logic                  w_rd_valid;
    logic                  w_wr_ok;
    logic                  w_commit_ok;
    logic                  w_release_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_beats_nxt;
    logic [2:0]            w_new_err;
    logic [BW-1:0]         w_wr_ptr_nxt;
    logic [BW-1:0]         w_rd_ptr_nxt;

    always_comb begin
        w_wr_ready   = (r_full_cnt < NB_CNT);
        w_rd_valid   = (r_full_cnt != '0);
        w_wr_ok      = wr_en & w_wr_ready;
        w_commit_ok  = wr_commit & w_wr_ready;
        w_release_ok = rd_release & w_rd_valid;
        w_rd_ok      = rd_en & w_rd_valid;
        w_new_err    = {rd_release & ~w_rd_valid, wr_commit & ~w_wr_ready, wr_en & ~w_wr_ready};
        // a write in the commit cycle still counts toward the committed tile
        w_beats_nxt  = (w_wr_ok && r_beats != BEAT_MAX) ? r_beats + 1'b1 : r_beats;
        w_wr_ptr_nxt = (r_wr_ptr == LAST_BANK) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == LAST_BANK) ? '0 : r_rd_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr_mask[b]) begin
                    r_mem[r_wr_ptr][wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_full_cnt <= '0;
            r_beats    <= '0;
            r_err      <= '0;
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                r_tile_len[i] <= '0;
            end
        end else begin
            if (w_commit_ok) begin
                r_tile_len[r_wr_ptr] <= w_beats_nxt;
                r_beats              <= '0;
                r_wr_ptr             <= w_wr_ptr_nxt;
            end else begin
                r_beats <= w_beats_nxt;
            end
            if (w_release_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_commit_ok && !w_release_ok) begin
                r_full_cnt <= r_full_cnt + 1'b1;
            end else if (!w_commit_ok && w_release_ok) begin
                r_full_cnt <= r_full_cnt - 1'b1;
            end
            r_err <= (err_clr ? 3'b000 : r_err) | w_new_err;
        end
    end

    // Each stage only reloads when valid data arrives, so the last stage holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pvld <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_pdata[i] <= '0;
            end
        end else begin
            r_pvld[0] <= w_rd_ok;
            if (w_rd_ok) begin
                r_pdata[0] <= r_mem[r_rd_ptr][rd_addr];
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_pvld[i] <= r_pvld[i-1];
                if (r_pvld[i-1]) begin
                    r_pdata[i] <= r_pdata[i-1];
                end
            end
        end
    end

    always_comb begin
        wr_ready      = w_wr_ready;
        rd_valid      = w_rd_valid;
        rd_tile_len   = r_tile_len[r_rd_ptr];
        rd_data       = r_pdata[RD_LATENCY-1];
        rd_data_valid = r_pvld[RD_LATENCY-1];
        wr_bank       = r_wr_ptr;
        rd_bank       = r_rd_ptr;
        full_cnt      = r_full_cnt;
        err           = r_err;
    end

endmodule

// File: tb/tb_pp_tile_buffer.sv
// Directed bench for pp_tile_buffer: a queue-based model of the bank ring checked every cycle,
// plus literal expectations for the key scenarios.
module tb_pp_tile_buffer;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = 2;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_mask;
    logic          wr_commit;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_release;
    logic          rd_valid;
    logic [AW:0]   rd_tile_len;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full_cnt;
    logic          err_clr;
    logic [2:0]    err;

    pp_tile_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_commit(wr_commit), .wr_ready(wr_ready), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_valid(rd_valid),
        .rd_tile_len(rd_tile_len), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .full_cnt(full_cnt), .err_clr(err_clr), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- model ----------------
    typedef struct { int due; logic [DW-1:0] d; } rd_t;
    rd_t           q[$];
    logic [DW-1:0] m_mem [NB][1<<AW];
    int            m_tl [NB];
    int            m_fc, m_wp, m_rp, m_beats, m_n;
    logic [2:0]    m_err;
    logic          m_dv;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NB; i++) m_tl[i] = 0;
        m_fc = 0; m_wp = 0; m_rp = 0; m_beats = 0; m_n = 0;
        m_err = 3'b000; m_dv = 1'b0; m_data = '0;
    endtask

    task automatic model_update();
        bit       can_wr, can_rd;
        int       inc, dec;
        logic [2:0] ne;
        if (!rst_n) begin
            model_reset();
            return;
        end
        can_wr = (m_fc < NB);
        can_rd = (m_fc > 0);
        inc = 0; dec = 0; ne = 3'b000;
        if (rd_en && can_rd) q.push_back('{due: m_n + L, d: m_mem[m_rp][rd_addr]});
        if (wr_en) begin
            if (can_wr) begin
                for (int b = 0; b < 4; b++)
                    if (wr_mask[b]) m_mem[m_wp][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
                if (m_beats < (1 << AW)) m_beats++;
            end else ne[0] = 1'b1;
        end
        if (wr_commit) begin
            if (can_wr) begin
                m_tl[m_wp] = m_beats;
                m_beats = 0;
                m_wp = (m_wp + 1) % NB;
                inc = 1;
            end else ne[1] = 1'b1;
        end
        if (rd_release) begin
            if (can_rd) begin
                m_rp = (m_rp + 1) % NB;
                dec = 1;
            end else ne[2] = 1'b1;
        end
        if (err_clr) m_err = 3'b000;
        m_err = m_err | ne;
        m_fc = m_fc + inc - dec;
        m_n++;
        m_dv = 1'b0;
        if (q.size() > 0 && q[0].due == m_n) begin
            m_dv = 1'b1;
            m_data = q[0].d;
            void'(q.pop_front());
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk(64'(wr_ready), 64'(m_fc < NB), "wr_ready");
        chk(64'(rd_valid), 64'(m_fc > 0), "rd_valid");
        chk(64'(full_cnt), 64'(m_fc), "full_cnt");
        chk(64'(wr_bank), 64'(m_wp), "wr_bank");
        chk(64'(rd_bank), 64'(m_rp), "rd_bank");
        chk(64'(rd_tile_len), 64'(m_tl[m_rp]), "rd_tile_len");
        chk(64'(err), 64'(m_err), "err");
        chk(64'(rd_data_valid), 64'(m_dv), "rd_data_valid");
        chk(64'(rd_data), 64'(m_data), "rd_data");
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; err_clr = 0;
        wr_mask = 4'h0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m,
                      input bit commit);
        wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m; wr_commit = commit;
        step();
        idle();
    endtask

    task automatic commit_only();
        wr_commit = 1; step(); idle();
    endtask

    task automatic release_only();
        rd_release = 1; step(); idle();
    endtask

    task automatic read_word(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        int  lat;
        bit  got;
        rd_en = 1; rd_addr = a;
        step();
        idle();
        lat = 1; got = 0;
        for (int i = 0; i < L + 3 && !got; i++) begin
            if (rd_data_valid) got = 1;
            else begin step(); lat++; end
        end
        chk(64'(got), 64'd1, {nm, "_arrived"});
        chk(64'(rd_data), 64'(exp), nm);
        chk(64'(lat), 64'(L), {nm, "_latency"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        chk(64'(wr_ready), 64'd1, "rst_wr_ready");
        chk(64'(rd_valid), 64'd0, "rst_rd_valid");
        chk(64'(full_cnt), 64'd0, "rst_full_cnt");
        chk(64'(err), 64'd0, "rst_err");
        rst_n = 1;
        step();

        // basic tile: 4 words, commit, pipelined reads
        for (int i = 0; i < 4; i++) wr(AW'(i), 32'h11111111 * (i + 1), 4'hF, 0);
        commit_only();
        chk(64'(rd_valid), 64'd1, "t1_rd_valid");
        chk(64'(full_cnt), 64'd1, "t1_full_cnt");
        chk(64'(rd_tile_len), 64'd4, "t1_tile_len");
        chk(64'(wr_bank), 64'd1, "t1_wr_bank");
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin rd_en = 1; rd_addr = AW'(j); end
            else rd_en = 0;
            step();
            if (j >= L - 1) begin
                chk(64'(rd_data_valid), 64'd1, "t1_pipe_valid");
                chk(64'(rd_data), 64'(32'h11111111 * (j - L + 2)), "t1_pipe_data");
            end else chk(64'(rd_data_valid), 64'd0, "t1_pipe_early");
        end
        idle();
        step();
        chk(64'(rd_data), 64'h44444444, "t1_hold");
        release_only();

        // byte mask into bank 1
        wr(4'd5, 32'hAABBCCDD, 4'hF, 0);
        wr(4'd5, 32'h11223344, 4'h5, 0);
        commit_only();
        read_word(4'd5, 32'hAA22CC44, "mask");

        // fill ring: write in commit cycle lands in committed bank
        wr(4'd0, 32'hDEADBEEF, 4'hF, 1);
        chk(64'(wr_ready), 64'd0, "full_wr_ready");
        chk(64'(full_cnt), 64'd2, "full_cnt2");
        wr(4'd0, 32'h0BADF00D, 4'hF, 0);
        chk(64'(err), 64'd1, "err_drop");
        commit_only();
        chk(64'(err), 64'd3, "err_overflow");
        release_only();
        chk(64'(wr_ready), 64'd1, "rel_wr_ready");
        chk(64'(wr_bank), 64'd1, "rel_wr_bank");
        chk(64'(rd_tile_len), 64'd1, "commit_cycle_len");
        read_word(4'd0, 32'hDEADBEEF, "no_overwrite");
        err_clr = 1; step(); idle();
        chk(64'(err), 64'd0, "err_clr");

        // simultaneous commit and release
        wr(4'd3, 32'h5A5A5A5A, 4'hF, 0);
        wr_commit = 1; rd_release = 1; step(); idle();
        chk(64'(full_cnt), 64'd1, "sim_full_cnt");
        chk(64'(wr_bank), 64'd0, "sim_wr_bank");
        chk(64'(rd_bank), 64'd1, "sim_rd_bank");
        read_word(4'd3, 32'h5A5A5A5A, "sim_read");

        // beat counter saturation at depth
        for (int i = 0; i < 18; i++) wr(AW'(i % 16), 32'h1000 + i, 4'hF, i == 17);
        release_only();
        chk(64'(rd_tile_len), 64'd16, "sat_tile_len");
        release_only();
        chk(64'(full_cnt), 64'd0, "empty_full_cnt");

        // read while empty ignored; release underflow; new error beats err_clr
        rd_en = 1; rd_addr = 4'd1; step(); idle();
        for (int i = 0; i < L + 1; i++) step();
        release_only();
        chk(64'(err), 64'd4, "err_underflow");
        chk(64'(full_cnt), 64'd0, "underflow_cnt");
        rd_release = 1; err_clr = 1; step(); idle();
        chk(64'(err), 64'd4, "err_new_wins");
        err_clr = 1; step(); idle();
        chk(64'(err), 64'd0, "err_clr2");

        // reset with a read in flight
        wr(4'd2, 32'h77777777, 4'hF, 1);
        rd_en = 1; rd_addr = 4'd2; step(); idle();
        rst_n = 0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < L + 1; i++) begin
            step();
            chk(64'(rd_data_valid), 64'd0, "rst_flush_valid");
        end
        rst_n = 1;
        step();
        chk(64'(full_cnt), 64'd0, "rst2_full_cnt");
        chk(64'(wr_ready), 64'd1, "rst2_wr_ready");
        chk(64'(rd_data), 64'd0, "rst2_rd_data");
        chk(64'(wr_bank), 64'd0, "rst2_wr_bank");
        for (int i = 0; i < L + 1; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
